// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiplier built from four passes through an external 4x4
// combinational multiplier, one nibble partial product per MUL cycle.
module mul8_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_c
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state, state_nx;
  logic [1:0]  k, k_nx;
  logic [7:0]  a_q, b_q, a_nx, b_nx;
  logic [15:0] acc, acc_nx, p_nx, term;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= 2'd0;
      acc   <= 16'd0;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      p     <= 16'd0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      acc   <= acc_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      p     <= p_nx;
    end
  end

  // Partial product weight: k[1] selects aH (x16), k[0] selects bH (x16).
  always_comb begin
    term = {8'h00, mul_c};
    case (k)
      2'd0:    term = {8'h00, mul_c};
      2'd1,
      2'd2:    term = {8'h00, mul_c} << 4;
      default: term = {8'h00, mul_c} << 8;
    endcase
  end

  always_comb begin
    state_nx = state;
    k_nx     = k;
    acc_nx   = acc;
    a_nx     = a_q;
    b_nx     = b_q;
    p_nx     = p;
    mul_a    = 4'd0;
    mul_b    = 4'd0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          a_nx     = a;
          b_nx     = b;
          acc_nx   = 16'd0;
          k_nx     = 2'd0;
          state_nx = MUL;
        end
      end
      MUL: begin
        mul_a  = k[1] ? a_q[7:4] : a_q[3:0];
        mul_b  = k[0] ? b_q[7:4] : b_q[3:0];
        acc_nx = acc + term;
        k_nx   = k + 2'd1;
        if (k == 2'd3) begin
          p_nx     = acc + term;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed and random checks of mul8_seq_ctrl against plain a*b arithmetic,
// with the external 4x4 multiplier modelled as a continuous assignment.
module tb_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [7:0]  a, b, mul_c;
  logic        busy, done;
  logic [15:0] p;
  logic [3:0]  mul_a, mul_b;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mp = 16'd0;

  mul8_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .p(p),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c)
  );

  assign mul_c = 8'(mul_a) * 8'(mul_b);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge. Runs one operation and returns at the negedge
  // of the first IDLE cycle after DONE, with start low.
  task automatic op(input logic [7:0] ai, input logic [7:0] bi, input bit hold,
                    input logic [7:0] ah, input logic [7:0] bh, input string tag);
    int first, ndone, nbusy;
    bit prev_d, dbl, mulbad, heldbad;
    logic [15:0] pd, exp_p;
    first = 0; ndone = 0; nbusy = 0;
    prev_d = 0; dbl = 0; mulbad = 0; heldbad = 0; pd = 16'hxxxx;
    exp_p = 16'(ai) * 16'(bi);
    start = 1'b1; a = ai; b = bi;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (hold) begin start = 1'b1; a = ah; b = bh; end
        else begin start = 1'b0; a = 8'($urandom); b = 8'($urandom); end
      end
      if (i == 5) start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) begin first = i; pd = p; end
        if (prev_d) dbl = 1;
      end
      prev_d = done;
      if (busy) nbusy++;
      if ((!busy || done) && (mul_a != 4'd0 || mul_b != 4'd0)) mulbad = 1;
      if (first == 0 && p !== mp) heldbad = 1;
    end
    mp = exp_p;
    check({tag, " latency"},    32'(first),  32'd5);
    check({tag, " done_count"}, 32'(ndone),  32'd1);
    check({tag, " done_width"}, 32'(dbl),    32'd0);
    check({tag, " busy_cycles"},32'(nbusy),  32'd5);
    check({tag, " p_at_done"},  32'(pd),     32'(exp_p));
    check({tag, " p_held"},     32'(p),      32'(exp_p));
    check({tag, " mul_idle0"},  32'(mulbad), 32'd0);
    check({tag, " p_prev_held"},32'(heldbad),32'd0);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst p",    32'(p),     32'd0);
    check("rst busy", 32'(busy),  32'd0);
    check("rst done", 32'(done),  32'd0);
    check("rst mul",  32'({mul_a, mul_b}), 32'd0);

    // start on the very first edge out of reset
    rst_n = 1'b1;
    op(8'hFF, 8'hFF, 0, 8'h00, 8'h00, "ffxff");
    check("ffxff const", 32'(p), 32'h0000FE01);
    op(8'h12, 8'h34, 0, 8'h00, 8'h00, "12x34");
    check("12x34 const", 32'(p), 32'h000003A8);
    op(8'h00, 8'hB7, 0, 8'h00, 8'h00, "00xb7");
    op(8'h01, 8'h80, 0, 8'h00, 8'h00, "01x80");
    check("01x80 const", 32'(p), 32'h00000080);

    // start held high with new operands through MUL/DONE must be ignored
    op(8'h0F, 8'hF0, 1, 8'hFF, 8'hFF, "ignore_start");
    check("ignore_start const", 32'(p), 32'h00000E10);

    // reset at the edge that processes k=2 aborts with no done
    start = 1'b1; a = 8'h55; b = 8'hAA;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("abort p",    32'(p),    32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort mul",  32'({mul_a, mul_b}), 32'd0);
    mp = 16'd0;
    rst_n = 1'b1;
    nd = 0;
    repeat (6) begin @(negedge clk); if (done) nd++; end
    check("abort no_done", 32'(nd), 32'd0);
    op(8'h55, 8'hAA, 0, 8'h00, 8'h00, "55xaa");
    check("55xaa const", 32'(p), 32'h00003872);

    // back-to-back: start on the edge right after DONE
    op(8'h10, 8'h10, 0, 8'h00, 8'h00, "b2b");
    check("b2b const", 32'(p), 32'h00000100);

    for (int n = 0; n < 1000; n++)
      op(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
